// File: rtl/branch_sequencer_pkg.sv
// Shared types for the tiny CPU control path: instruction classes and sequencer states.
package cpu_ctrl_pkg;

  localparam int FLAG_W = 4;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'b00,
    CLS_BRANCH = 2'b01,
    CLS_NOP    = 2'b10,
    CLS_HALT   = 2'b11
  } inst_class_t;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_EXEC    = 3'd1,
    ST_COND    = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_HALT    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive un-acked fetch cycles and flags expiry on the last allowed cycle.
// FETCH_TIMEOUT = 0 removes the counter and never expires.
module fetch_timeout_counter #(
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic active_in,
  input  logic ack_in,
  output logic expire_out
);

  generate
    if (FETCH_TIMEOUT == 0) begin : g_off
      logic unused_s;
      assign unused_s   = &{1'b0, clk_in, reset_in, active_in, ack_in};
      assign expire_out = 1'b0;
    end else begin : g_on
      localparam int CW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
      localparam logic [CW-1:0] LIMIT = CW'(FETCH_TIMEOUT - 1);

      logic [CW-1:0] cnt_r;

      // Count waiting cycles; any ack or leaving FETCH restarts the count.
      always_ff @(posedge clk_in) begin
        if (reset_in) begin
          cnt_r <= {CW{1'b0}};
        end else if (active_in && !ack_in) begin
          cnt_r <= cnt_r + CW'(1);
        end else begin
          cnt_r <= {CW{1'b0}};
        end
      end

      assign expire_out = active_in && !ack_in && (cnt_r == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle control FSM: fetch handshake, ALU/branch strobes, PC update, halt/fault.
// Optional taken-branch counter enabled by defining BRANCH_STATS_EN.
module branch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 15,
  parameter int CNT_W         = 8
) (
  input  logic              clk_in,
  input  logic              reset_in,
  output logic              fetch_req_out,
  input  logic              fetch_ack_in,
  input  logic [1:0]        dec_class_in,
  input  logic              dec_flag_we_in,
  input  logic [FLAG_W-1:0] dec_cond_mask_in,
  input  logic              dec_cond_inv_in,
  output logic              status_write_en_out,
  output logic              status_copy_en_out,
  output logic [FLAG_W-1:0] status_inst_out,
  output logic              status_invert_out,
  input  logic              cond_in,
  output logic              pc_inc_out,
  output logic              pc_load_out,
  output logic              halted_out,
  output logic              fault_out,
  output logic [CNT_W-1:0]  taken_count_out
);

  seq_state_t        state_r;
  logic              fetch_req_r;
  logic              write_en_r;
  logic              copy_en_r;
  logic [FLAG_W-1:0] inst_r;
  logic              inv_r;
  logic              pc_inc_r;
  logic              halted_r;
  logic              fault_r;

  inst_class_t dec_class_s;
  logic        fetch_act_s;
  logic        ack_s;
  logic        expire_s;
  logic        resolve_s;

  assign dec_class_s = inst_class_t'(dec_class_in);
  // An ack only counts once the request is actually on the bus.
  assign fetch_act_s = (state_r == ST_FETCH) && fetch_req_r;
  assign ack_s       = fetch_act_s && fetch_ack_in;
  assign resolve_s   = (state_r == ST_RESOLVE) && !reset_in;

  fetch_timeout_counter #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_timeout (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .active_in (fetch_act_s),
    .ack_in    (fetch_ack_in),
    .expire_out(expire_s)
  );

  // Sequencer state with registered strobes for the state being entered.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_r     <= ST_FETCH;
      fetch_req_r <= 1'b0;
      write_en_r  <= 1'b0;
      copy_en_r   <= 1'b0;
      inst_r      <= {FLAG_W{1'b0}};
      inv_r       <= 1'b0;
      pc_inc_r    <= 1'b0;
      halted_r    <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      fetch_req_r <= 1'b0;
      write_en_r  <= 1'b0;
      copy_en_r   <= 1'b0;
      inst_r      <= {FLAG_W{1'b0}};
      inv_r       <= 1'b0;
      pc_inc_r    <= 1'b0;
      case (state_r)
        ST_FETCH: begin
          if (ack_s) begin
            case (dec_class_s)
              CLS_ALU: begin
                state_r    <= ST_EXEC;
                write_en_r <= dec_flag_we_in;
                pc_inc_r   <= 1'b1;
              end
              CLS_NOP: begin
                state_r  <= ST_EXEC;
                pc_inc_r <= 1'b1;
              end
              CLS_BRANCH: begin
                state_r   <= ST_COND;
                copy_en_r <= 1'b1;
                inst_r    <= dec_cond_mask_in;
                inv_r     <= dec_cond_inv_in;
              end
              CLS_HALT: begin
                state_r  <= ST_HALT;
                halted_r <= 1'b1;
              end
              default: begin
                state_r  <= ST_HALT;
                halted_r <= 1'b1;
              end
            endcase
          end else if (expire_s) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
            fault_r  <= 1'b1;
          end else begin
            state_r     <= ST_FETCH;
            fetch_req_r <= 1'b1;
          end
        end
        ST_EXEC: begin
          state_r     <= ST_FETCH;
          fetch_req_r <= 1'b1;
        end
        ST_COND: begin
          state_r <= ST_RESOLVE;
        end
        ST_RESOLVE: begin
          state_r     <= ST_FETCH;
          fetch_req_r <= 1'b1;
        end
        ST_HALT: begin
          state_r  <= ST_HALT;
          halted_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_FETCH;
          fetch_req_r <= 1'b1;
        end
      endcase
    end
  end

  assign fetch_req_out       = fetch_req_r;
  assign status_write_en_out = write_en_r;
  assign status_copy_en_out  = copy_en_r;
  assign status_inst_out     = inst_r;
  assign status_invert_out   = inv_r;
  assign halted_out          = halted_r;
  assign fault_out           = fault_r;
  // cond_in is only valid in RESOLVE itself, so the PC choice is taken directly from it.
  assign pc_inc_out          = pc_inc_r | (resolve_s & ~cond_in);
  assign pc_load_out         = resolve_s & cond_in;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_cnt_r;

  // Saturating count of taken branches.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      taken_cnt_r <= {CNT_W{1'b0}};
    end else if (resolve_s && cond_in && (taken_cnt_r != {CNT_W{1'b1}})) begin
      taken_cnt_r <= taken_cnt_r + CNT_W'(1);
    end else begin
      taken_cnt_r <= taken_cnt_r;
    end
  end

  assign taken_count_out = taken_cnt_r;
`else
  assign taken_count_out = {CNT_W{1'b0}};
`endif

endmodule
